regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file and shares it between two writeback requesters: port A (ALU result) and port B (load/memory result).
- After reset, sequences a zero-clear sweep of x1..x31 through the same write port, then round-robin arbitrates requester writes.
- Registers the winning write so rf_we/rf_waddr/rf_wdata are stable before the register file's negedge write.
- Suppresses writes to x0 and counts cycles in which a requester was stalled.

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. After reset it clears x1..x31,
// then shares the port between port A (ALU) and port B (load) with round-robin arbitration.
module regfile_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int INIT_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t           RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t              state_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic                last_b_q;
    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic                init_done_q;
    logic [CNT_W-1:0]    stall_q;
    logic [CNT_W-1:0]    stall_d;

    logic run;
    logic grant_a;
    logic grant_b;
    logic stall;

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        run     = (state_q == ST_RUN);
        grant_a = a_valid & (~b_valid | last_b_q);
        grant_b = b_valid & (~a_valid | ~last_b_q);
        a_ready = run & grant_a;
        b_ready = run & grant_b;
        stall   = run & ((a_valid & ~grant_a) | (b_valid & ~grant_b));
        stall_d = stall_q;
        if (stall && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            sweep_q     <= ADDR_W'(1);
            last_b_q    <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The sweep counter wraps to zero once the top register has been issued.
                    if (sweep_q == '0) begin
                        rf_we_q     <= 1'b0;
                        init_done_q <= 1'b1;
                        state_q     <= ST_RUN;
                    end else begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= sweep_q;
                        rf_wdata_q <= '0;
                        sweep_q    <= sweep_q + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                    stall_q     <= stall_d;
                    if (a_ready) begin
                        rf_we_q    <= (a_addr != '0);
                        rf_waddr_q <= a_addr;
                        rf_wdata_q <= a_data;
                        last_b_q   <= 1'b0;
                    end else if (b_ready) begin
                        rf_we_q    <= (b_addr != '0);
                        rf_waddr_q <= b_addr;
                        rf_wdata_q <= b_data;
                        last_b_q   <= 1'b1;
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a cycle-level reference model,
// plus a second small-counter instance for stall saturation.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int STALL_MAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, rf_waddr;
    logic [DW-1:0] a_data, b_data, rf_wdata;
    logic          rf_we, init_done;
    logic [15:0]   stall_cnt;

    logic          s_rst_n;
    logic          s_a_valid, s_b_valid, s_a_ready, s_b_ready;
    logic [AW-1:0] s_a_addr, s_b_addr, s_rf_waddr;
    logic [DW-1:0] s_a_data, s_b_data, s_rf_wdata;
    logic          s_rf_we, s_init_done;
    logic [3:0]    s_stall_cnt;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_EN(1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .init_done(init_done), .stall_cnt(stall_cnt)
    );

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_EN(0), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(s_rst_n),
        .a_valid(s_a_valid), .a_addr(s_a_addr), .a_data(s_a_data), .a_ready(s_a_ready),
        .b_valid(s_b_valid), .b_addr(s_b_addr), .b_data(s_b_data), .b_ready(s_b_ready),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .init_done(s_init_done), .stall_cnt(s_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset release, who won last, expected registered outputs.
    int            m_edge;
    bit            m_run;
    bit            m_last_b;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_init_done;
    int            m_stall;
    bit            m_ga, m_gb;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_run = 0; m_last_b = 1; m_we = 0; m_waddr = '0; m_wdata = '0;
        m_init_done = 0; m_stall = 0; m_ga = 0; m_gb = 0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_we"}, rf_we, 0);
        check_eq({tag, "_waddr"}, rf_waddr, 0);
        check_eq({tag, "_wdata"}, rf_wdata, 0);
        check_eq({tag, "_init_done"}, init_done, 0);
        check_eq({tag, "_stall"}, stall_cnt, 0);
        check_eq({tag, "_a_ready"}, a_ready, 0);
        check_eq({tag, "_b_ready"}, b_ready, 0);
    endtask

    // Called just after a negedge with inputs applied; returns just after the following negedge.
    task automatic step();
        #1;
        m_ga = 0; m_gb = 0;
        if (m_run) begin
            if (a_valid && b_valid) begin
                if (m_last_b) m_ga = 1; else m_gb = 1;
            end else if (a_valid) m_ga = 1;
            else if (b_valid) m_gb = 1;
        end
        check_eq("a_ready", a_ready, m_ga);
        check_eq("b_ready", b_ready, m_gb);
        @(posedge clk);
        #1;
        if (!m_run) begin
            m_edge++;
            if (m_edge <= 31) begin
                m_we = 1; m_waddr = AW'(m_edge); m_wdata = '0;
            end else begin
                m_we = 0; m_init_done = 1; m_run = 1;
            end
        end else begin
            if ((a_valid && !m_ga) || (b_valid && !m_gb)) begin
                if (m_stall < STALL_MAX) m_stall++;
            end
            if (m_ga) begin
                m_waddr = a_addr; m_wdata = a_data; m_we = (a_addr != 0); m_last_b = 0;
                $display("txn A addr=%0d data=%08h we=%0d", a_addr, a_data, m_we);
            end else if (m_gb) begin
                m_waddr = b_addr; m_wdata = b_data; m_we = (b_addr != 0); m_last_b = 1;
                $display("txn B addr=%0d data=%08h we=%0d", b_addr, b_data, m_we);
            end else begin
                m_we = 0;
            end
        end
        check_eq("rf_we", rf_we, m_we);
        check_eq("rf_waddr", rf_waddr, m_waddr);
        check_eq("rf_wdata", rf_wdata, m_wdata);
        check_eq("init_done", init_done, m_init_done);
        check_eq("stall_cnt", stall_cnt, m_stall);
        @(negedge clk);
    endtask

    initial begin : main
        int            stall_before;
        logic [AW-1:0] seq [4];
        seq[0] = 5'd3; seq[1] = 5'd7; seq[2] = 5'd3; seq[3] = 5'd7;

        reset_n = 1'b0; s_rst_n = 1'b0;
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        s_a_valid = 1; s_a_addr = 5'd1; s_a_data = 32'h11;
        s_b_valid = 1; s_b_addr = 5'd2; s_b_data = 32'h22;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Clear sweep, no requests.
        for (int i = 0; i < 32; i++) step();

        // Single A write.
        a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        step();
        check_eq("a_only_addr", rf_waddr, 5);
        check_eq("a_only_data", rf_wdata, 32'hDEADBEEF);
        a_valid = 0;
        step();

        // B write to x0 is consumed but not written.
        b_valid = 1; b_addr = 5'd0; b_data = 32'h1234;
        step();
        check_eq("b_x0_we", rf_we, 0);
        b_valid = 0;
        step();

        // Both valid for 4 cycles: alternating grants.
        stall_before = m_stall;
        a_valid = 1; a_addr = 5'd3; a_data = 32'hAAAA0003;
        b_valid = 1; b_addr = 5'd7; b_data = 32'hBBBB0007;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("alt_waddr", rf_waddr, seq[i]);
        end
        check_eq("alt_stall_delta", stall_cnt, stall_before + 4);
        a_valid = 0; b_valid = 0;

        // Randomized traffic honouring the hold-until-accepted contract.
        for (int i = 0; i < 300; i++) begin
            if (!a_valid || m_ga) begin
                a_valid = ($urandom_range(0, 9) < 6);
                a_addr  = AW'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || m_gb) begin
                b_valid = ($urandom_range(0, 9) < 6);
                b_addr  = AW'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            step();
        end

        // Asynchronous reset mid-RUN with a grant pending.
        a_valid = 1; a_addr = 5'd9; a_data = 32'h99; b_valid = 0;
        #2 reset_n = 1'b0;
        #1 check_zero("rst_run");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("mid_init_x10", rf_waddr, 10);

        // Asynchronous reset mid-INIT; sweep restarts from x1.
        #2 reset_n = 1'b0;
        #1 check_zero("rst_init");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        a_valid = 0;
        step();
        check_eq("restart_x1", rf_waddr, 1);
        for (int i = 0; i < 31; i++) step();

        // Small-counter instance: one port stalled every cycle, counter saturates at 15.
        @(negedge clk);
        s_rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check_eq("sat_stall", s_stall_cnt, (k > 15) ? 15 : k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
